// File: rtl/seg_scan_mux.sv
// Time-multiplexed 3-digit seven-segment driver: scans ones/tens/hundreds onto a shared
// segment bus with an all-off gap between digits and optional leading-zero blanking.
module seg_scan_mux #(
  parameter int          DWELL_CYC   = 1000,
  parameter int          BLANK_CYC   = 50,
  parameter int          SEG_ACT_LOW = 1,
  parameter int          DIG_ACT_LOW = 1,
  parameter int          LZB_EN      = 1,
  parameter logic [7:0]  ZERO_PAT    = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  output logic [7:0] seg_out,
  output logic [2:0] dig_sel,
  output logic       frame_start
);

  localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ON0  = 3'd1;
  localparam logic [2:0] S_BLK0 = 3'd2;
  localparam logic [2:0] S_ON1  = 3'd3;
  localparam logic [2:0] S_BLK1 = 3'd4;
  localparam logic [2:0] S_ON2  = 3'd5;
  localparam logic [2:0] S_BLK2 = 3'd6;

  localparam logic [7:0]    SEG_OFF    = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [2:0]    DIG_OFF    = (DIG_ACT_LOW != 0) ? 3'b111 : 3'b000;
  localparam logic          NO_GAP     = (BLANK_CYC <= 0);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          enter_s;
  logic [7:0]    snap0_r;
  logic [7:0]    snap1_r;
  logic [7:0]    snap2_r;
  logic          blank1_r;
  logic          blank2_r;
  logic          lzb1_s;
  logic          lzb2_s;
  logic [7:0]    seg_s;
  logic [2:0]    dig_s;

  function automatic logic [2:0] dig_on(input logic [1:0] idx);
    logic [2:0] onehot;
    onehot = 3'b001 << idx;
    return (DIG_ACT_LOW != 0) ? ~onehot : onehot;
  endfunction

  // Next-state: dwell/gap timing per state; dropping en aborts to IDLE from anywhere
  always_comb begin
    state_s = state_r;
    if (!en) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: state_s = S_ON0;
        S_ON0:  if (cnt_r == DWELL_LAST) state_s = NO_GAP ? S_ON1 : S_BLK0; else state_s = S_ON0;
        S_BLK0: if (cnt_r == BLANK_LAST) state_s = S_ON1;                   else state_s = S_BLK0;
        S_ON1:  if (cnt_r == DWELL_LAST) state_s = NO_GAP ? S_ON2 : S_BLK1; else state_s = S_ON1;
        S_BLK1: if (cnt_r == BLANK_LAST) state_s = S_ON2;                   else state_s = S_BLK1;
        S_ON2:  if (cnt_r == DWELL_LAST) state_s = NO_GAP ? S_ON0 : S_BLK2; else state_s = S_ON2;
        S_BLK2: if (cnt_r == BLANK_LAST) state_s = S_ON0;                   else state_s = S_BLK2;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Counter restarts on every state change; blanking flags are derived from the incoming snapshot
  always_comb begin
    enter_s = (state_s == S_ON0) && (state_r != S_ON0);
    if ((state_s != state_r) || (state_s == S_IDLE)) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
    lzb2_s = (LZB_EN != 0) && (seg2 == ZERO_PAT);
    lzb1_s = lzb2_s && (seg1 == ZERO_PAT);
  end

  // Output decode for the state being entered; ON0 entry takes seg0 straight from the input
  always_comb begin
    seg_s = SEG_OFF;
    dig_s = DIG_OFF;
    case (state_s)
      S_ON0: begin
        seg_s = enter_s ? seg0 : snap0_r;
        dig_s = dig_on(2'd0);
      end
      S_ON1: begin
        if (blank1_r) begin
          seg_s = SEG_OFF;
          dig_s = DIG_OFF;
        end else begin
          seg_s = snap1_r;
          dig_s = dig_on(2'd1);
        end
      end
      S_ON2: begin
        if (blank2_r) begin
          seg_s = SEG_OFF;
          dig_s = DIG_OFF;
        end else begin
          seg_s = snap2_r;
          dig_s = dig_on(2'd2);
        end
      end
      default: begin
        seg_s = SEG_OFF;
        dig_s = DIG_OFF;
      end
    endcase
  end

  // State and dwell counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Frame snapshot: captured only on ON0 entry so a frame never mixes two counter values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap0_r  <= SEG_OFF;
      snap1_r  <= SEG_OFF;
      snap2_r  <= SEG_OFF;
      blank1_r <= 1'b0;
      blank2_r <= 1'b0;
    end else if (enter_s) begin
      snap0_r  <= seg0;
      snap1_r  <= seg1;
      snap2_r  <= seg2;
      blank1_r <= lzb1_s;
      blank2_r <= lzb2_s;
    end else begin
      snap0_r  <= snap0_r;
      snap1_r  <= snap1_r;
      snap2_r  <= snap2_r;
      blank1_r <= blank1_r;
      blank2_r <= blank2_r;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out     <= SEG_OFF;
      dig_sel     <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= seg_s;
      dig_sel     <= dig_s;
      frame_start <= enter_s;
    end
  end

  seg_scan_mux_chk #(
    .SEG_ACT_LOW(SEG_ACT_LOW),
    .DIG_ACT_LOW(DIG_ACT_LOW)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .seg_out(seg_out),
    .dig_sel(dig_sel)
  );

endmodule

// Display-safety properties: one digit at most, and a dark bus whenever no digit is selected.
module seg_scan_mux_chk #(
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input logic       clk,
  input logic       rst,
  input logic [7:0] seg_out,
  input logic [2:0] dig_sel
);

  localparam logic [7:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [2:0] dig_act;
  assign dig_act = (DIG_ACT_LOW != 0) ? ~dig_sel : dig_sel;

  a_one_digit: assert property (@(posedge clk) disable iff (rst) $countones(dig_act) <= 1);
  a_dark_bus:  assert property (@(posedge clk) disable iff (rst) (dig_act == 3'b000) |-> (seg_out == SEG_OFF));

endmodule
